// File: rtl/tap_ctrl_pkg.sv
// Shared definitions for the tap window controller.
//   DEF_DW / DEF_DEPTH / DEF_CW : default sample width, tap count, counter width
//   tap_state_e                 : 2-bit sequencer state encoding
package tap_ctrl_pkg;

  localparam int DEF_DW    = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_CW    = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } tap_state_e;

endpackage

// File: rtl/tap_shift_bank.sv
// Enable-gated delay line of DEPTH samples with synchronous clear.
//   clk, reset (async, active-low)
//   shift_en : move every tap one position older and load din into tap0
//   clr      : synchronous clear of all taps (wins over shift_en)
//   din      : sample entering tap0
//   taps     : tap k at [k*DW +: DW], tap0 newest
module tap_shift_bank
  import tap_ctrl_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                shift_en,
  input  logic                clr,
  input  logic [DW-1:0]       din,
  output logic [DW*DEPTH-1:0] taps
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      taps <= '0;
    end else if (clr) begin
      taps <= '0;
    end else if (shift_en) begin
      taps <= {taps[DW*(DEPTH-1)-1:0], din};
    end
  end

endmodule

// File: rtl/tap_window_ctrl.sv
// Sequencer for the tap delay line: accepts a framed sample stream, shifts it
// into the tap bank on accepted samples and presents each full tap window
// downstream. After the last sample of a frame it shifts in DEPTH-1 zeros so
// that N input samples produce exactly N output windows.
//   clk, reset (async, active-low), flush (sync abort to IDLE)
//   in_valid/in_ready/in_data/in_last : upstream sample stream
//   out_valid/out_ready/out_taps/out_last : downstream window stream
//   busy      : sequencer not in IDLE
//   fsm_state : current sequencer state (debug observation)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// 1. A producer holds valid and its payload stable until that transfer; valid
// never drops without one (flush and reset excepted).
module tap_window_ctrl
  import tap_ctrl_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = DEF_CW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW*DEPTH-1:0] out_taps,
  output logic                out_last,
  output logic                busy,
  output logic [1:0]          fsm_state
);

  localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] DRAIN_INIT = CW'(DEPTH - 1);

  tap_state_e    cur_state, nxt_state;
  logic [CW-1:0] cnt, cnt_d;
  logic [CW-1:0] drain_cnt, drain_d;
  logic          out_valid_d, out_last_d;
  logic          accept, out_hs, final_hs, drain_shift, shift;
  logic          bank_clr;
  logic [CW-1:0] cnt_inc;
  logic [DW-1:0] bank_din;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= ST_IDLE;
      cnt       <= '0;
      drain_cnt <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      cnt       <= cnt_d;
      drain_cnt <= drain_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
    end
  end

  always_comb begin
    nxt_state   = cur_state;
    cnt_d       = cnt;
    drain_d     = drain_cnt;
    out_valid_d = out_valid;
    out_last_d  = out_last;
    bank_clr    = 1'b0;

    unique case (cur_state)
      ST_IDLE, ST_FILL: in_ready = 1'b1;
      ST_STREAM:        in_ready = !out_valid || out_ready;
      default:          in_ready = 1'b0;
    endcase
    if (flush) in_ready = 1'b0;

    accept      = in_valid && in_ready;
    out_hs      = out_valid && out_ready;
    final_hs    = out_hs && out_last;
    // A pad shift may only replace the window once the current one is gone.
    drain_shift = (cur_state == ST_DRAIN) && (drain_cnt != '0) &&
                  (!out_valid || out_ready) && !flush;
    shift       = accept || drain_shift;
    cnt_inc     = (cnt == CNT_FULL) ? CNT_FULL : cnt + CW'(1);
    bank_din    = (cur_state == ST_DRAIN) ? '0 : in_data;

    if (flush) begin
      nxt_state   = ST_IDLE;
      cnt_d       = '0;
      drain_d     = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      bank_clr    = 1'b1;
    end else if (final_hs) begin
      // No shift can coincide here: in_ready is 0 in DRAIN and drain_cnt is 0.
      nxt_state   = ST_IDLE;
      cnt_d       = '0;
      drain_d     = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      bank_clr    = 1'b1;
    end else begin
      if (out_hs) out_valid_d = 1'b0;
      if (shift) begin
        cnt_d = cnt_inc;
        // Short frames count pad shifts too, so the first window can come
        // from a pad shift.
        if (cnt_inc == CNT_FULL) out_valid_d = 1'b1;
      end
      if (drain_shift) begin
        drain_d = drain_cnt - CW'(1);
        if (drain_cnt == CW'(1)) out_last_d = 1'b1;
      end
      if (accept) begin
        if (in_last) begin
          nxt_state = ST_DRAIN;
          drain_d   = DRAIN_INIT;
        end else if (cnt_inc == CNT_FULL) begin
          nxt_state = ST_STREAM;
        end else begin
          nxt_state = ST_FILL;
        end
      end
    end
  end

  tap_shift_bank #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_bank (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift),
    .clr      (bank_clr),
    .din      (bank_din),
    .taps     (out_taps)
  );

  assign busy      = (cur_state != ST_IDLE);
  assign fsm_state = cur_state;

endmodule

// File: tb/tb_tap_window_ctrl.sv
module tb_tap_window_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int W     = DW * DEPTH;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_taps;
  logic          out_last;
  logic          busy;
  logic [1:0]    fsm_state;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_last_q[$];
  logic [W-1:0] obs_q[$];
  logic         obs_last_q[$];

  tap_window_ctrl #(.DW(DW), .DEPTH(DEPTH), .CW(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_taps  (out_taps),
    .out_last  (out_last),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // one clock: sample handshakes at the negedge, record any accepted window
  task automatic step(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      obs_q.push_back(out_taps);
      obs_last_q.push_back(out_last);
    end
    @(posedge clk);
    #1;
  endtask

  // present one sample until accepted; rnd adds in_valid gaps and random out_ready
  task automatic send_sample(input logic [DW-1:0] d, input logic l, input bit rnd);
    bit acc;
    int budget;
    acc = 1'b0;
    budget = 0;
    if (rnd && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      step(acc);
      acc = 1'b0;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!acc && budget < 200) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      step(acc);
      budget++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: sample %h not accepted within %0d cycles", d, budget);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    bit acc;
    int budget;
    budget = 0;
    while (busy && budget < 400) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      step(acc);
      budget++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, budget);
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b required 0", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (out_taps !== '0) begin errors++; $display("FAIL rst_taps: got %h required 0", out_taps); end
    checks++; if (fsm_state !== S_IDLE) begin errors++; $display("FAIL rst_state: got %0d required %0d", fsm_state, S_IDLE); end
    cycle();
    cycle();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
    cycle();
  endtask

  task automatic test_fill_stream();
    out_ready = 1'b1;
    send_sample(8'h11, 1'b0, 1'b0);
    send_sample(8'h12, 1'b0, 1'b0);
    send_sample(8'h13, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_no_valid: got %b required 0", out_valid); end
    send_sample(8'h14, 1'b0, 1'b0);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fill_valid: got %b required 1", out_valid); end
    checks++; if (out_taps !== 32'h11121314) begin errors++; $display("FAIL fill_taps: got %h required 11121314", out_taps); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL fill_last: got %b required 0", out_last); end
    checks++; if (fsm_state !== S_STREAM) begin errors++; $display("FAIL fill_state: got %0d required %0d", fsm_state, S_STREAM); end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1;
    in_data  = 8'h15;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b required 0", i, in_ready); end
      checks++; if (out_taps !== 32'h11121314 || out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d]: got valid=%b taps=%h required 1/11121314", i, out_valid, out_taps);
      end
      cycle();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b required 1", in_ready); end
    cycle();
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++; if (out_taps !== 32'h12131415 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_next_window: got valid=%b taps=%h required 1/12131415", out_valid, out_taps);
    end
    do_flush();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_cleanup: got busy=%b valid=%b required 0/0", busy, out_valid);
    end
  endtask

  task automatic test_frame();
    logic [W-1:0] exp_w [5];
    exp_w[0] = 32'h11121314; exp_w[1] = 32'h12131415; exp_w[2] = 32'h13141500;
    exp_w[3] = 32'h14150000; exp_w[4] = 32'h15000000;
    obs_q.delete(); obs_last_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_sample(8'h11 + 8'(i), (i == 4), 1'b0);
    wait_idle(1'b0);
    checks++; if (obs_q.size() != 5) begin errors++; $display("FAIL frame_count: got %0d windows required 5", obs_q.size()); end
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_w[i] || obs_last_q[i] !== (i == 4)) begin
        errors++; $display("FAIL frame_win[%0d]: got %h last=%b required %h last=%b", i, obs_q[i], obs_last_q[i], exp_w[i], (i == 4));
      end
    end
    checks++; if (out_taps !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL frame_end: got taps=%h busy=%b required 0/0", out_taps, busy);
    end
  endtask

  task automatic test_single();
    obs_q.delete(); obs_last_q.delete();
    out_ready = 1'b1;
    send_sample(8'hAA, 1'b1, 1'b0);
    wait_idle(1'b0);
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d windows required 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      checks++; if (obs_q[0] !== 32'hAA000000 || obs_last_q[0] !== 1'b1) begin
        errors++; $display("FAIL single_win: got %h last=%b required aa000000 last=1", obs_q[0], obs_last_q[0]);
      end
    end
    checks++; if (fsm_state !== S_IDLE) begin errors++; $display("FAIL single_state: got %0d required %0d", fsm_state, S_IDLE); end
  endtask

  task automatic test_flush();
    bit acc;
    int budget;
    out_ready = 1'b0;
    send_sample(8'h31, 1'b0, 1'b0);
    send_sample(8'h32, 1'b1, 1'b0);
    budget = 0;
    while (!out_valid && budget < 20) begin step(acc); budget++; end
    checks++; if (out_valid !== 1'b1 || fsm_state !== S_DRAIN || out_taps !== 32'h31320000) begin
      errors++; $display("FAIL flush_pre: got valid=%b state=%0d taps=%h required 1/%0d/31320000", out_valid, fsm_state, out_taps, S_DRAIN);
    end
    flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b required 0", in_ready); end
    cycle();
    flush = 1'b0;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_taps !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_clear: got valid=%b last=%b taps=%h busy=%b required all 0", out_valid, out_last, out_taps, busy);
    end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_again: got %b required 1", in_ready); end
    cycle();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_sample(8'h41 + 8'(i), 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ares_pre_valid: got %b required 1", out_valid); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_taps !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL ares_clear: got valid=%b taps=%h busy=%b required 0/0/0", out_valid, out_taps, busy);
    end
    reset = 1'b1;
    cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_sample(8'h21 + 8'(i), 1'b0, 1'b0);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_taps !== 32'h21222324) begin
      errors++; $display("FAIL ares_recover: got valid=%b taps=%h required 1/21222324", out_valid, out_taps);
    end
    do_flush();
  endtask

  // scoreboard: windows are derived from each frame padded with DEPTH-1 zeros
  task automatic test_random();
    logic [DW-1:0] frame[$];
    logic [DW-1:0] pad[$];
    logic [W-1:0]  w;
    logic [W-1:0]  e;
    logic          el;
    int n;
    obs_q.delete(); obs_last_q.delete();
    exp_q.delete(); exp_last_q.delete();
    for (int f = 0; f < 20; f++) begin
      n = $urandom_range(1, 7);
      frame.delete();
      for (int i = 0; i < n; i++) frame.push_back(DW'($urandom_range(1, 255)));
      pad = frame;
      for (int i = 0; i < DEPTH - 1; i++) pad.push_back('0);
      for (int i = DEPTH - 1; i <= n + DEPTH - 2; i++) begin
        w = '0;
        for (int k = 0; k < DEPTH; k++) w[k*DW +: DW] = pad[i-k];
        exp_q.push_back(w);
        exp_last_q.push_back(i == n + DEPTH - 2);
      end
      for (int i = 0; i < n; i++) send_sample(frame[i], (i == n - 1), 1'b1);
    end
    wait_idle(1'b1);
    out_ready = 1'b0;
    checks++; if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d windows required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
      e  = exp_q.pop_front();
      el = exp_last_q.pop_front();
      checks++; if (obs_q[i] !== e || obs_last_q[i] !== el) begin
        errors++; $display("FAIL rand_win[%0d]: got %h last=%b required %h last=%b", i, obs_q[i], obs_last_q[i], e, el);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_stream();
    test_backpressure();
    test_frame();
    test_single();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
